// File: rtl/alu_muldiv_seq_pkg.sv
// rtl/alu_muldiv_seq_pkg.sv - shared types for the iterative MUL/DIVU/REMU sequencer
// Purpose: data bus type, ALU control codes, sequencer op codes and FSM states.
// Ports: none (package).
package alu_muldiv_seq_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] DATA_BUS;

  // Shared ALU control; SLT_OP is an unsigned less-than returning 0/1.
  typedef enum logic [1:0] {
    SUM_OP = 2'b00,
    SUB_OP = 2'b01,
    SLT_OP = 2'b10
  } alu_op_t;

  // Encoding 2'b11 is reserved and answered with a zero result.
  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_DIVU = 2'b01,
    MD_REMU = 2'b10
  } md_op_t;

  typedef enum logic [2:0] {
    MD_IDLE     = 3'd0,
    MD_MUL_STEP = 3'd1,
    MD_DIV_CMP  = 3'd2,
    MD_DIV_SUB  = 3'd3,
    MD_DONE     = 3'd4
  } md_state_t;

  localparam int MD_CNT_W = $clog2(XLEN);

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// rtl/alu_muldiv_seq_alu.sv - shared ALU slice used by the sequencer (sum, sub, unsigned slt)
// Purpose: purely combinational ALU; one add/subtract/compare per cycle.
// Ports:
//   op1, op2 : DATA_BUS operands
//   ctrl     : alu_op_t operation select
//   result   : DATA_BUS result (SLT returns 0 or 1)
module alu_muldiv_seq_alu
  import alu_muldiv_seq_pkg::*;
(
  input  DATA_BUS op1,
  input  DATA_BUS op2,
  input  alu_op_t ctrl,
  output DATA_BUS result
);

  always_comb begin
    result = '0;
    case (ctrl)
      SUM_OP:  result = op1 + op2;
      SUB_OP:  result = op1 - op2;
      SLT_OP:  result = (op1 < op2) ? DATA_BUS'(1) : DATA_BUS'(0);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative RV32M MUL/DIVU/REMU sequencer on the shared ALU
// Purpose: shift-add multiply (W cycles) and restoring divide (2 cycles per bit),
//   one request at a time over valid/ready, result held until consumed.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake; ready only when idle and out of reset
//   req_op, req_a, req_b : operation and operands
//   resp_valid/resp_ready: response handshake; resp_data stable while resp_valid
//   resp_data            : result
//   busy                 : high whenever the sequencer is not idle
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    req_valid,
  output logic    req_ready,
  input  md_op_t  req_op,
  input  DATA_BUS req_a,
  input  DATA_BUS req_b,
  output logic    resp_valid,
  input  logic    resp_ready,
  output DATA_BUS resp_data,
  output logic    busy
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(DATA_WIDTH - 1);

  md_state_t             state_q, state_d;
  DATA_BUS               r_q, r_d;       // MUL accumulator / DIV remainder
  DATA_BUS               d_q, d_d;       // MUL multiplicand / DIV divisor
  DATA_BUS               q_q, q_d;       // MUL multiplier / DIV quotient
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  lt_q, lt_d;     // shifted remainder is below the divisor
  md_op_t                op_q, op_d;
  logic                  resp_valid_q, resp_valid_d;
  DATA_BUS               resp_data_q, resp_data_d;

  DATA_BUS               alu_a, alu_b, alu_res;
  alu_op_t               alu_ctrl;
  DATA_BUS               r_shift;
  logic                  carry;

  alu_muldiv_seq_alu u_alu (
    .op1    (alu_a),
    .op2    (alu_b),
    .ctrl   (alu_ctrl),
    .result (alu_res)
  );

  assign req_ready  = (state_q == MD_IDLE) && !rst;
  assign busy       = (state_q != MD_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  // Remainder shifted left with the next dividend bit; the bit shifted out
  // is the carry that forces a subtract when the true value exceeds 2^W.
  assign r_shift = {r_q[DATA_WIDTH-2:0], q_q[DATA_WIDTH-1]};
  assign carry   = r_q[DATA_WIDTH-1];

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    d_d          = d_q;
    q_d          = q_q;
    cnt_d        = cnt_q;
    lt_d         = lt_q;
    op_d         = op_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    alu_a        = '0;
    alu_b        = '0;
    alu_ctrl     = SUM_OP;

    case (state_q)
      MD_IDLE: begin
        if (req_valid && req_ready) begin
          op_d  = req_op;
          cnt_d = '0;
          lt_d  = 1'b0;
          case (req_op)
            MD_MUL: begin
              r_d     = '0;
              d_d     = req_a;
              q_d     = req_b;
              state_d = MD_MUL_STEP;
            end
            MD_DIVU, MD_REMU: begin
              if (req_b == '0) begin
                state_d      = MD_DONE;
                resp_valid_d = 1'b1;
                resp_data_d  = (req_op == MD_DIVU) ? '1 : req_a;
              end else begin
                r_d     = '0;
                d_d     = req_b;
                q_d     = req_a;
                state_d = MD_DIV_CMP;
              end
            end
            default: begin
              state_d      = MD_DONE;
              resp_valid_d = 1'b1;
              resp_data_d  = '0;
            end
          endcase
        end
      end

      MD_MUL_STEP: begin
        alu_a    = r_q;
        alu_b    = d_q;
        alu_ctrl = SUM_OP;
        if (q_q[0]) r_d = alu_res;
        d_d   = d_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d      = MD_DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = r_d;
        end
      end

      MD_DIV_CMP: begin
        alu_a    = r_shift;
        alu_b    = d_q;
        alu_ctrl = SLT_OP;
        r_d      = r_shift;
        q_d      = q_q << 1;
        // With a carry the true remainder is >= 2^W, so it is never below D.
        lt_d     = (alu_res != '0) && !carry;
        state_d  = MD_DIV_SUB;
      end

      MD_DIV_SUB: begin
        alu_a    = r_q;
        alu_b    = d_q;
        alu_ctrl = SUB_OP;
        if (!lt_q) begin
          r_d = alu_res;
          q_d = {q_q[DATA_WIDTH-1:1], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d      = MD_DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = (op_q == MD_REMU) ? r_d : q_d;
        end else begin
          state_d = MD_DIV_CMP;
        end
      end

      MD_DONE: begin
        if (resp_ready) begin
          state_d      = MD_IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MD_IDLE;
      r_q          <= '0;
      d_q          <= '0;
      q_q          <= '0;
      cnt_q        <= '0;
      lt_q         <= 1'b0;
      op_q         <= MD_MUL;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      d_q          <= d_d;
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      lt_q         <= lt_d;
      op_q         <= op_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed self-checking bench for alu_muldiv_seq
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    req_valid;
  logic    req_ready;
  md_op_t  req_op;
  DATA_BUS req_a;
  DATA_BUS req_b;
  logic    resp_valid;
  logic    resp_ready;
  DATA_BUS resp_data;
  logic    busy;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the acceptance edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
    logic [1:0] op_v;
    op_v      = op;
    req_op    = md_op_t'(op_v);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    check({31'b0, req_ready}, 32'd1, {tag, " req_ready before accept"});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    check({31'b0, busy}, 32'd1, {tag, " busy after accept"});
  endtask

  // Waits for the response, checks latency and data, optionally stalls, then consumes it.
  task automatic finish(input logic [31:0] exp, input int exp_lat, input int hold,
                        input bit noisy, input string tag);
    int lat;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      if (noisy) begin
        req_valid = 1'b1;
        req_op    = MD_MUL;
        req_a     = $urandom;
        req_b     = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    req_valid = 1'b0;
    check({31'b0, resp_valid}, 32'd1, {tag, " resp_valid"});
    check(lat, exp_lat, {tag, " latency"});
    check(resp_data, exp, {tag, " data"});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check(resp_data, exp, {tag, " data held"});
      check({31'b0, resp_valid, req_ready}, 32'd2, {tag, " valid held, not ready"});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({29'b0, resp_valid, busy, req_ready}, 32'd1, {tag, " idle after consume"});
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = MD_MUL;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    #1;
    check({31'b0, req_ready}, 32'd0, "req_ready in reset");
    repeat (3) @(posedge clk);
    #1;
    check({31'b0, req_ready}, 32'd0, "req_ready in reset after edges");
    check({30'b0, resp_valid, busy}, 32'd0, "reset valid/busy");
    check(resp_data, 32'd0, "reset resp_data");
    rst = 1'b0;
    #1;
    check({31'b0, req_ready}, 32'd1, "req_ready out of reset");

    send(2'b00, 32'd7, 32'd6, "mul 7*6");
    finish(32'd42, 33, 0, 1'b1, "mul 7*6");

    send(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul ff*ff");
    finish(32'h0000_0001, 33, 0, 1'b0, "mul ff*ff");

    send(2'b00, 32'h0001_0000, 32'h0001_0000, "mul 2^16*2^16");
    finish(32'h0, 33, 0, 1'b0, "mul 2^16*2^16");

    send(2'b01, 32'd100, 32'd7, "divu 100/7");
    finish(32'd14, 65, 0, 1'b1, "divu 100/7");

    send(2'b10, 32'd100, 32'd7, "remu 100/7");
    finish(32'd2, 65, 0, 1'b0, "remu 100/7");

    send(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, "divu carry");
    finish(32'd1, 65, 0, 1'b0, "divu carry");

    send(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, "remu carry");
    finish(32'h7FFF_FFFE, 65, 0, 1'b0, "remu carry");

    send(2'b01, 32'd5, 32'd0, "divu by zero");
    finish(32'hFFFF_FFFF, 1, 0, 1'b0, "divu by zero");

    send(2'b10, 32'd5, 32'd0, "remu by zero");
    finish(32'd5, 1, 0, 1'b0, "remu by zero");

    send(2'b11, 32'd9, 32'd3, "reserved op");
    finish(32'd0, 1, 0, 1'b0, "reserved op");

    send(2'b01, 32'd1000, 32'd10, "divu backpressure");
    finish(32'd100, 65, 10, 1'b0, "divu backpressure");

    // Reset in the middle of a divide: nothing may come out afterwards.
    send(2'b01, 32'd12345, 32'd67, "divu reset");
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check({30'b0, resp_valid, busy}, 32'd0, "mid-op reset valid/busy");
    check(resp_data, 32'd0, "mid-op reset resp_data");
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
        @(posedge clk);
        #1;
        if (resp_valid || busy) seen = 1'b1;
      end
      check({31'b0, seen}, 32'd0, "no response after reset");
    end

    send(2'b00, 32'd123, 32'd1000, "mul after reset");
    finish(32'd123000, 33, 0, 1'b0, "mul after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
